nfc_op_sched: RTL and testbench

Two-requester operation scheduler for a single NAND flash channel. It arbitrates page-level READ, PROGRAM and ERASE requests from two clients round-robin. For the winner it sequences the command, address, data and busy phases on the flash pins, then returns a completion with error status. It sits between the copy/maintenance engines and one flash device. Its flash interface is the same pin set the NFC read/program paths drive.

---
 rtl/nfc_pkg.sv | 47 ++++
 rtl/nfc_rr_arb.sv | 27 ++
 rtl/nfc_op_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_nfc_op_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_pkg.sv
// Shared types and constants for the NAND flash channel operation scheduler.
package nfc_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_PROG  = 2'd1,
    OP_ERASE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE, CMD1, ADDR, RDATA, WDATA, CMD2, TWB, BUSY, DONE
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h00;
  localparam logic [7:0] CMD_PROG      = 8'h80;
  localparam logic [7:0] CMD_PROG_CFM  = 8'h10;
  localparam logic [7:0] CMD_ERASE     = 8'h60;
  localparam logic [7:0] CMD_ERASE_CFM = 8'hD0;

  localparam int unsigned ADDR_CYC_PAGE  = 3;
  localparam int unsigned ADDR_CYC_BLOCK = 2;

  function automatic logic [7:0] cmd1_byte(op_e op);
    case (op)
      OP_PROG:  return CMD_PROG;
      OP_ERASE: return CMD_ERASE;
      default:  return CMD_READ;
    endcase
  endfunction

  function automatic logic [7:0] cmd2_byte(op_e op);
    return (op == OP_ERASE) ? CMD_ERASE_CFM : CMD_PROG_CFM;
  endfunction

  // Erase omits the column byte, so its first address cycle carries page[7:0].
  function automatic logic [7:0] addr_byte(op_e op, logic [8:0] page, logic [9:0] idx);
    logic [9:0] k;
    k = (op == OP_ERASE) ? idx + 10'd1 : idx;
    case (k)
      10'd1:   return page[7:0];
      10'd2:   return {7'b0, page[8]};
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/nfc_rr_arb.sv
// Two-way round-robin arbiter; the pointer toggles on every advance strobe.
module nfc_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] win
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (rst)      ptr <= 1'b0;
    else if (adv) ptr <= ~ptr;
  end

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/nfc_op_sched.sv
// Two-requester READ/PROG/ERASE scheduler for one NAND flash channel.
module nfc_op_sched
  import nfc_pkg::*;
#(
  parameter int unsigned PAGE_BYTES   = 512,
  parameter int unsigned TWB_CYCLES   = 10,
  parameter int unsigned BUSY_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_op0,
  input  logic [1:0] req_op1,
  input  logic [8:0] req_page0,
  input  logic [8:0] req_page1,
  output logic [1:0] grant,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic [7:0] wr_data0,
  input  logic [7:0] wr_data1,
  output logic       wr_ack,
  output logic [1:0] cmp_valid,
  output logic       cmp_err,
  inout  wire  [7:0] F_IO,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_WEN,
  output logic       F_REN,
  input  logic       F_RB
);

  localparam logic [9:0]  PAGE_LAST = 10'(PAGE_BYTES - 1);
  localparam logic [15:0] TWB_LAST  = 16'(TWB_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(BUSY_TIMEOUT - 1);

  state_e      state, state_n;
  op_e         op_q, op_n;
  logic        phase, phase_n;
  logic [9:0]  bcnt, bcnt_n;
  logic [15:0] tcnt, tcnt_n;
  logic        own, own_n;
  logic [8:0]  page_q, page_n;
  logic        err, err_n;
  logic [1:0]  win;
  logic        adv;
  logic        cle_n, ale_n, wen_n, ren_n, oe_n;
  logic [7:0]  io_n, io_q, io_out;
  logic        io_oe;
  logic        rd_cap;

  assign adv = (state == DONE);

  nfc_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .adv (adv),
    .win (win)
  );

  always_comb begin
    state_n = state;
    phase_n = phase;
    bcnt_n  = bcnt;
    tcnt_n  = tcnt;
    own_n   = own;
    op_n    = op_q;
    page_n  = page_q;
    err_n   = err;
    case (state)
      IDLE: if (win != 2'b00) begin
        own_n   = win[1];
        op_n    = op_e'(win[1] ? req_op1 : req_op0);
        page_n  = win[1] ? req_page1 : req_page0;
        phase_n = 1'b0;
        bcnt_n  = '0;
        err_n   = (op_n == OP_RSVD);
        state_n = (op_n == OP_RSVD) ? DONE : CMD1;
      end
      CMD1: begin
        phase_n = ~phase;
        if (phase) begin
          bcnt_n  = '0;
          state_n = ADDR;
        end
      end
      ADDR: begin
        phase_n = ~phase;
        if (phase) begin
          bcnt_n = bcnt + 10'd1;
          if (bcnt == ((op_q == OP_ERASE) ? 10'(ADDR_CYC_BLOCK - 1) : 10'(ADDR_CYC_PAGE - 1))) begin
            bcnt_n  = '0;
            tcnt_n  = '0;
            state_n = (op_q == OP_READ) ? TWB : (op_q == OP_PROG) ? WDATA : CMD2;
          end
        end
      end
      WDATA: begin
        phase_n = ~phase;
        if (phase) begin
          bcnt_n = bcnt + 10'd1;
          if (bcnt == PAGE_LAST) begin
            bcnt_n  = '0;
            state_n = CMD2;
          end
        end
      end
      CMD2: begin
        phase_n = ~phase;
        if (phase) begin
          tcnt_n  = '0;
          state_n = TWB;
        end
      end
      TWB: begin
        tcnt_n = tcnt + 16'd1;
        if (tcnt == TWB_LAST) begin
          tcnt_n  = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        tcnt_n = tcnt + 16'd1;
        if (F_RB) begin
          bcnt_n  = '0;
          phase_n = 1'b0;
          state_n = (op_q == OP_READ) ? RDATA : DONE;
        end else if (tcnt == TO_LAST) begin
          err_n   = 1'b1;
          state_n = DONE;
        end
      end
      RDATA: begin
        phase_n = ~phase;
        if (phase) begin
          bcnt_n = bcnt + 10'd1;
          if (bcnt == PAGE_LAST) begin
            bcnt_n  = '0;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    cle_n = 1'b0;
    ale_n = 1'b0;
    wen_n = 1'b1;
    ren_n = 1'b1;
    oe_n  = 1'b0;
    io_n  = '0;
    case (state_n)
      CMD1: begin
        cle_n = 1'b1;
        oe_n  = 1'b1;
        wen_n = phase_n;
        io_n  = cmd1_byte(op_n);
      end
      CMD2: begin
        cle_n = 1'b1;
        oe_n  = 1'b1;
        wen_n = phase_n;
        io_n  = cmd2_byte(op_n);
      end
      ADDR: begin
        ale_n = 1'b1;
        oe_n  = 1'b1;
        wen_n = phase_n;
        io_n  = addr_byte(op_n, page_n, bcnt_n);
      end
      WDATA: begin
        oe_n  = 1'b1;
        wen_n = phase_n;
      end
      RDATA:   ren_n = phase_n;
      default: ;
    endcase
  end

  assign rd_cap = (state == RDATA) && !phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 1'b0;
      bcnt     <= '0;
      tcnt     <= '0;
      own      <= 1'b0;
      op_q     <= OP_READ;
      page_q   <= '0;
      err      <= 1'b0;
      F_CLE    <= 1'b0;
      F_ALE    <= 1'b0;
      F_WEN    <= 1'b1;
      F_REN    <= 1'b1;
      io_oe    <= 1'b0;
      io_q     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bcnt     <= bcnt_n;
      tcnt     <= tcnt_n;
      own      <= own_n;
      op_q     <= op_n;
      page_q   <= page_n;
      err      <= err_n;
      F_CLE    <= cle_n;
      F_ALE    <= ale_n;
      F_WEN    <= wen_n;
      F_REN    <= ren_n;
      io_oe    <= oe_n;
      io_q     <= io_n;
      rd_valid <= rd_cap;
      if (rd_cap) rd_data <= F_IO;
    end
  end

  // Program bytes bypass io_q so the owner's next byte appears right after wr_ack.
  always_comb begin
    io_out = io_q;
    if (state == WDATA) io_out = own ? wr_data1 : wr_data0;
  end

  assign F_IO = io_oe ? io_out : 'z;

  always_comb begin
    grant     = '0;
    cmp_valid = '0;
    req_ready = '0;
    if (state == IDLE) req_ready = win;
    if (state == DONE) cmp_valid[own] = 1'b1;
    else if (state != IDLE) grant[own] = 1'b1;
  end

  assign cmp_err = (state == DONE) && err;
  assign wr_ack  = (state == WDATA) && phase;

endmodule

// File: tb/tb_nfc_op_sched.sv
// Randomized bench for nfc_op_sched with a flash pin model and op-level reference.
module tb_nfc_op_sched;

  localparam int unsigned PB  = 512;
  localparam int unsigned TWB = 10;
  localparam int unsigned TO  = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [1:0] req_op0 = '0, req_op1 = '0;
  logic [8:0] req_page0 = '0, req_page1 = '0;
  logic [1:0] grant;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] wr_data0, wr_data1;
  logic       wr_ack;
  logic [1:0] cmp_valid;
  logic       cmp_err;
  wire  [7:0] F_IO;
  logic       F_CLE, F_ALE, F_WEN, F_REN;
  logic       F_RB = 1'b1;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic        rr_ptr = 1'b0;
  logic [8:0]  cur_page = '0;
  int unsigned rd_idx = 0;
  int unsigned wr_idx = 0;
  logic [7:0]  fl_byte;

  always #5 clk = ~clk;

  nfc_op_sched #(.PAGE_BYTES(PB), .TWB_CYCLES(TWB), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_page0(req_page0), .req_page1(req_page1),
    .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
    .cmp_valid(cmp_valid), .cmp_err(cmp_err),
    .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN),
    .F_RB(F_RB)
  );

  function automatic logic [7:0] flash_byte(logic [8:0] pg, int unsigned idx);
    return 8'(idx * 37) ^ pg[7:0] ^ 8'(idx >> 8);
  endfunction

  assign fl_byte  = flash_byte(cur_page, rd_idx);
  assign F_IO     = (F_REN == 1'b0) ? fl_byte : 8'hzz;
  assign wr_data1 = wr_idx[7:0];
  assign wr_data0 = wr_idx[7:0] + 8'h40;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One request round: arbitration, full pin sequence, data, latency and completion.
  task automatic run_op(input logic [1:0] mask, input logic [1:0] op0, input logic [1:0] op1,
                        input logic [8:0] pg0, input logic [8:0] pg1,
                        input int unsigned hold, input int unsigned abort_at);
    int unsigned w, pre, busy, rdn, exp_n, L, n, lim;
    int unsigned rd_n, rd_err, wr_n, gerr, stab, nmis, last_rd, bad;
    logic [1:0] op, oh, cv;
    logic [8:0] pg;
    logic       tmo, done, got, ce, wr_pend, ren_pend, last_wen_low, last_ren_low;
    logic [1:0] gd;
    logic [9:0] exp_q[$], log_q[$], s, last_s;

    w  = (mask == 2'b11) ? int'(rr_ptr) : (mask[1] ? 1 : 0);
    op = w ? op1 : op0;
    pg = w ? pg1 : pg0;
    oh = 2'(1 << w);
    case (op)
      2'd0:    pre = 8 + TWB;
      2'd1:    pre = 8 + 2 * PB + 2 + TWB;
      2'd2:    pre = 6 + 2 + TWB;
      default: pre = 0;
    endcase
    tmo   = (op != 2'd3) && (hold >= TO);
    busy  = (op == 2'd3) ? 0 : (tmo ? TO : hold + 1);
    rdn   = (op == 2'd0 && !tmo) ? 2 * PB : 0;
    exp_n = 1 + pre + busy + rdn;
    L     = pre + hold;
    lim   = exp_n + 40;

    exp_q.delete();
    log_q.delete();
    case (op)
      2'd0: begin
        exp_q.push_back({2'b10, 8'h00}); exp_q.push_back({2'b01, 8'h00});
        exp_q.push_back({2'b01, pg[7:0]}); exp_q.push_back({2'b01, 7'b0, pg[8]});
      end
      2'd1: begin
        exp_q.push_back({2'b10, 8'h80}); exp_q.push_back({2'b01, 8'h00});
        exp_q.push_back({2'b01, pg[7:0]}); exp_q.push_back({2'b01, 7'b0, pg[8]});
        for (int unsigned k = 0; k < PB; k++)
          exp_q.push_back({2'b00, 8'(k) + (w == 0 ? 8'h40 : 8'h00)});
        exp_q.push_back({2'b10, 8'h10});
      end
      2'd2: begin
        exp_q.push_back({2'b10, 8'h60}); exp_q.push_back({2'b01, pg[7:0]});
        exp_q.push_back({2'b01, 7'b0, pg[8]}); exp_q.push_back({2'b10, 8'hD0});
      end
      default: ;
    endcase

    cur_page = pg;
    rd_idx   = 0;
    wr_idx   = 0;

    @(posedge clk); #1;
    req_valid = mask; req_op0 = op0; req_op1 = op1; req_page0 = pg0; req_page1 = pg1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("req_ready", req_ready, oh);
    if (!got) begin req_valid = '0; return; end

    n = 0; done = 1'b0; rd_n = 0; rd_err = 0; wr_n = 0; gerr = 0; stab = 0; last_rd = 0;
    wr_pend = 1'b0; ren_pend = 1'b0; last_wen_low = 1'b0; last_ren_low = 1'b0; last_s = '0;
    cv = '0; ce = 1'b0; gd = '0;
    while (!done && n < lim) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        req_valid = '0;
        req_op0 = 2'($urandom); req_op1 = 2'($urandom);
        req_page0 = 9'($urandom); req_page1 = 9'($urandom);
      end
      if (wr_pend) wr_idx++;
      if (ren_pend) rd_idx++;
      F_RB = (op != 2'd3 && n <= L) ? 1'b0 : 1'b1;
      @(negedge clk);
      s = {F_CLE, F_ALE, F_IO};
      if (!F_WEN) log_q.push_back(s);
      if (last_wen_low && (!F_WEN || s != last_s)) stab++;
      if (last_ren_low && !F_REN) stab++;
      if (!F_WEN && !F_REN) stab++;
      if (!F_REN && (F_CLE || F_ALE)) stab++;
      last_wen_low = !F_WEN; last_ren_low = !F_REN; last_s = s;
      if (rd_valid) begin
        if (rd_data !== flash_byte(pg, rd_n)) rd_err++;
        if (rd_n > 0 && n - last_rd != 2) rd_err++;
        last_rd = n;
        rd_n++;
      end
      wr_pend  = wr_ack;
      ren_pend = !F_REN;
      if (wr_ack) wr_n++;
      if (cmp_valid != 2'b00) begin
        done = 1'b1; cv = cmp_valid; ce = cmp_err; gd = grant;
      end else if (grant != ((op == 2'd3) ? 2'b00 : oh)) gerr++;
      if (abort_at != 0 && rd_n == abort_at) begin
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; F_RB = 1'b1;
        @(negedge clk);
        check("abort_pins", {F_CLE, F_ALE, F_WEN, F_REN, dut.io_oe}, 5'b00110);
        check("abort_outs", {grant, cmp_valid, rd_valid}, 5'b0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if ({grant, cmp_valid} != 4'b0) bad++;
        end
        check("abort_quiet", bad, 0);
        rr_ptr = 1'b0;
        rd_idx = 0;
        return;
      end
    end
    F_RB = 1'b1;

    check("done", done, 1);
    check("cmp_n", n, exp_n);
    check("cmp_valid", cv, oh);
    check("cmp_err", ce, (op == 2'd3) || tmo);
    check("grant_done", gd, 0);
    check("grant_hold", gerr, 0);
    nmis = 0;
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
      if (log_q[k] != exp_q[k]) nmis++;
    check("pin_len", log_q.size(), exp_q.size());
    check("pin_seq", nmis, 0);
    check("bus_form", stab, 0);
    check("rd_cnt", rd_n, (op == 2'd0 && !tmo) ? PB : 0);
    check("rd_data", rd_err, 0);
    check("wr_ack_cnt", wr_n, (op == 2'd1) ? PB : 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle", {grant, cmp_valid}, 0);
    if (done) rr_ptr = ~rr_ptr;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pins", {F_CLE, F_ALE, F_WEN, F_REN, dut.io_oe}, 5'b00110);
    check("rst_outs", {grant, req_ready, cmp_valid, cmp_err, rd_valid, wr_ack}, 9'b0);
    check("rst_rd_data", rd_data, 0);
    @(posedge clk); #1; rst = 1'b0;

    run_op(2'b01, 2'd0, 2'd0, 9'h1A5, 9'h000, 50, 0);
    run_op(2'b10, 2'd0, 2'd1, 9'h000, 9'h003, 20, 0);
    run_op(2'b11, 2'd2, 2'd2, 9'h010, 9'h020, 5, 0);
    run_op(2'b11, 2'd2, 2'd2, 9'h011, 9'h021, 7, 0);
    run_op(2'b01, 2'd2, 2'd0, 9'h100, 9'h000, 30, 0);
    run_op(2'b10, 2'd0, 2'd2, 9'h000, 9'h0C3, TO + 20, 0);
    run_op(2'b01, 2'd3, 2'd0, 9'h055, 9'h000, 0, 0);
    for (int i = 0; i < 5; i++)
      run_op(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             9'($urandom), 9'($urandom), $urandom_range(0, 40), 0);
    run_op(2'b01, 2'd0, 2'd0, 9'h0F0, 9'h000, 10, 200);
    run_op(2'b11, 2'd2, 2'd2, 9'h123, 9'h0AA, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
